// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - CPU/debug arbiter and sequencer for the single-port data RAM
// Define DATA_RAM_ARB_DBG_PORT_EN to arbitrate the debug port; otherwise the CPU owns the RAM.
module data_ram_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  output logic                  o_cpu_gnt,
  output logic                  o_cpu_rvalid,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  input  logic                  i_dbg_req,
  input  logic                  i_dbg_we,
  input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
  input  logic [DATA_WIDTH-1:0] i_dbg_wdata,
  output logic                  o_dbg_gnt,
  output logic                  o_dbg_rvalid,
  output logic [DATA_WIDTH-1:0] o_dbg_rdata,
  output logic                  o_ram_read,
  output logic                  o_ram_write,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata,
  output logic                  o_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;

  state_t                  state;
  logic                    lat_we;
  logic                    owner_dbg;
  logic                    dbg_req;
  logic                    dbg_wins;
  logic                    arb_fire;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

`ifdef DATA_RAM_ARB_DBG_PORT_EN
  logic [3:0] starve_cnt;

  // CPU has priority unless the debug port has lost STARVE_LIMIT contested rounds in a row.
  assign dbg_req   = i_dbg_req;
  assign dbg_wins  = i_dbg_req && (!i_cpu_req || (starve_cnt == 4'(STARVE_LIMIT)));
  assign sel_we    = dbg_wins ? i_dbg_we    : i_cpu_we;
  assign sel_addr  = dbg_wins ? i_dbg_addr  : i_cpu_addr;
  assign sel_wdata = dbg_wins ? i_dbg_wdata : i_cpu_wdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_cnt <= 4'd0;
    end else if (state == IDLE) begin
      if (dbg_wins || !i_dbg_req) begin
        starve_cnt <= 4'd0;
      end else if (starve_cnt != 4'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_dbg    <= 1'b0;
      o_dbg_gnt    <= 1'b0;
      o_dbg_rvalid <= 1'b0;
      o_dbg_rdata  <= '0;
    end else begin
      o_dbg_gnt    <= arb_fire && dbg_wins;
      o_dbg_rvalid <= (state == RDATA) && owner_dbg;
      if (arb_fire) begin
        owner_dbg <= dbg_wins;
      end
      if ((state == RDATA) && owner_dbg) begin
        o_dbg_rdata <= i_ram_rdata;
      end
    end
  end
`else
  logic unused_dbg;
  localparam int unused_limit = STARVE_LIMIT;

  assign dbg_req      = 1'b0;
  assign dbg_wins     = 1'b0;
  assign owner_dbg    = 1'b0;
  assign sel_we       = i_cpu_we;
  assign sel_addr     = i_cpu_addr;
  assign sel_wdata    = i_cpu_wdata;
  assign o_dbg_gnt    = 1'b0;
  assign o_dbg_rvalid = 1'b0;
  assign o_dbg_rdata  = '0;
  assign unused_dbg   = ^{i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata};
`endif

  assign arb_fire = (state == IDLE) && (i_cpu_req || dbg_req);
  assign o_busy   = (state != IDLE);

  // RAM command and grant are registered on entry to ISSUE so they sit high for exactly that cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      lat_we       <= 1'b0;
      o_cpu_gnt    <= 1'b0;
      o_cpu_rvalid <= 1'b0;
      o_cpu_rdata  <= '0;
      o_ram_read   <= 1'b0;
      o_ram_write  <= 1'b0;
      o_ram_addr   <= '0;
      o_ram_wdata  <= '0;
    end else begin
      o_cpu_gnt    <= arb_fire && !dbg_wins;
      o_ram_read   <= arb_fire && !sel_we;
      o_ram_write  <= arb_fire && sel_we;
      o_cpu_rvalid <= (state == RDATA) && !owner_dbg;
      case (state)
        IDLE: begin
          if (arb_fire) begin
            lat_we      <= sel_we;
            o_ram_addr  <= sel_addr;
            o_ram_wdata <= sel_wdata;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          state <= lat_we ? IDLE : RDATA;
        end
        RDATA: begin
          if (!owner_dbg) begin
            o_cpu_rdata <= i_ram_rdata;
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
